// File: rtl/lutram_walk_seq.sv
// Address-walk sequencer for single-port LUTRAM tests: checks INIT contents, writes the complement,
// reads it back and reports pass/fail. Define SEQ_WRITE_PHASE_EN to enable the write/readback phases.
module lutram_walk_seq #(
  parameter int            ADDR_W = 6,
  parameter logic [255:0]  INIT   = 256'hDEADBEEF0150BAD0CAFEF00D0F0FFFFF0123456789ABCDEFFEDCBA9876543210
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_d_o,
  input  logic              ram_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [7:0]        err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  // state    | meaning
  // IDLE     | waiting for start_i
  // CHK_INIT | compare read data against INIT, one address per cycle
  // WRITE    | write ~INIT, one address per cycle
  // CHK_WR   | compare read data against ~INIT
  // DONE     | results held until next start_i
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHK_INIT = 3'd1,
`ifdef SEQ_WRITE_PHASE_EN
    WRITE    = 3'd2,
    CHK_WR   = 3'd3,
`endif
    DONE     = 3'd4
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DEPTH-1:0] INIT_LO = INIT[DEPTH-1:0];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                d_q, d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [7:0]          err_q, err_d;
  logic [ADDR_W-1:0]   fail_q, fail_d;

  logic                check;
  logic                exp_bit;
  logic                finish;
  logic                last;
  logic [ADDR_W-1:0]   addr_nxt;

  assign last     = &addr_q;
  assign addr_nxt = addr_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    d_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    check   = 1'b0;
    exp_bit = 1'b0;
    finish  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = CHK_INIT;
          addr_d  = '0;
          err_d   = 8'd0;
          fail_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CHK_INIT: begin
        check   = 1'b1;
        exp_bit = INIT_LO[addr_q];
        addr_d  = addr_nxt;
        if (last) begin
`ifdef SEQ_WRITE_PHASE_EN
          state_d = WRITE;
          we_d    = 1'b1;
          d_d     = ~INIT_LO[addr_nxt];
`else
          state_d = DONE;
          finish  = 1'b1;
`endif
        end
      end
`ifdef SEQ_WRITE_PHASE_EN
      WRITE: begin
        addr_d = addr_nxt;
        if (last) begin
          state_d = CHK_WR;
        end else begin
          we_d = 1'b1;
          d_d  = ~INIT_LO[addr_nxt];
        end
      end
      CHK_WR: begin
        check   = 1'b1;
        exp_bit = ~INIT_LO[addr_q];
        addr_d  = addr_nxt;
        if (last) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // fail_addr captures only the first mismatch of a walk
    if (check && (ram_q_i != exp_bit)) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (err_q == 8'd0)  fail_d = addr_q;
    end

    if (finish) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_d == 8'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign ram_we_o    = we_q;
  assign ram_addr_o  = addr_q;
  assign ram_d_o     = d_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_q;
  assign fail_addr_o = fail_q;

endmodule
